countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/counter_pkg.sv | 10 +
 rtl/countdown_timer.sv | 96 +++++++++
 tb/tb_countdown_timer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared FSM state encoding for countdown_timer.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a single-cycle expiry pulse; Moore outputs only.
// Optional periodic mode: define COUNTDOWN_TIMER_AUTORELOAD_EN to restart from the last load value.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             decr,
  output logic [WIDTH-1:0] count_reg,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            count_d = load_value;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_d = load_value;
`endif
            state_d = (load_value != '0) ? RUN : EXPIRE;
          end
        end
        RUN: begin
          // Leaving RUN on the 1->0 step means the count can never wrap.
          if (decr) begin
            count_d = count_q - ONE;
            if (count_q == ONE) state_d = EXPIRE;
          end
        end
        EXPIRE: begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          if (reload_q != '0) begin
            state_d = RUN;
            count_d = reload_q;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      count_q <= '0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count_reg  = count_q;
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == EXPIRE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; autoreload vectors run when
// COUNTDOWN_TIMER_AUTORELOAD_EN is defined.
module tb_countdown_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             clear = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             load_ready;
  logic             decr = 1'b0;
  logic [WIDTH-1:0] count_reg;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .load_valid(load_valid),
    .load_value(load_value),
    .load_ready(load_ready),
    .decr      (decr),
    .count_reg (count_reg),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int cnt, input bit bsy, input bit dn);
    check_val({tag, ".count"}, 32'(count_reg), 32'(cnt));
    check_val({tag, ".busy"},  32'(busy),      32'(bsy));
    check_val({tag, ".ready"}, 32'(load_ready), 32'(!bsy));
    check_val({tag, ".done"},  32'(done),      32'(dn));
  endtask

  task automatic do_load(input int v);
    load_valid = 1'b1;
    load_value = WIDTH'(v);
    tick();
    load_valid = 1'b0;
    load_value = '0;
  endtask

  int exp_t2 [10] = '{5, 4, 4, 3, 3, 2, 2, 1, 1, 0};
  int done_seen;

  initial begin
    // Reset values while rstn is low
    #3;
    check_outs("reset", 0, 1'b0, 1'b0);
    #9 rstn = 1'b1;
    tick();
    check_outs("post_reset", 0, 1'b0, 1'b0);

    // Load 3, decr held: 3,2,1,0 with done on the cycle after the 1->0 edge
    decr = 1'b1;
    do_load(3);
    check_outs("t1.c0", 3, 1'b1, 1'b0);
    tick(); check_outs("t1.c1", 2, 1'b1, 1'b0);
    tick(); check_outs("t1.c2", 1, 1'b1, 1'b0);
    tick(); check_outs("t1.c3", 0, 1'b1, 1'b1);
    tick(); check_outs("t1.c4", 0, 1'b0, 1'b0);

    // Load 5, decr alternating; a load offered mid-run must be ignored
    done_seen = 0;
    do_load(5);
    for (int i = 0; i < 10; i++) begin
      decr = (i % 2 == 0);
      if (i == 1) begin
        load_valid = 1'b1;
        load_value = 8'd9;
      end else begin
        load_valid = 1'b0;
      end
      check_val($sformatf("t2.count%0d", i), 32'(count_reg), 32'(exp_t2[i]));
      check_val($sformatf("t2.done%0d", i), 32'(done), 32'(i == 9));
      if (done) done_seen++;
      tick();
    end
    load_valid = 1'b0;
    check_outs("t2.end", 0, 1'b0, 1'b0);
    check_val("t2.done_pulses", 32'(done_seen), 32'd1);

    // Load 0 goes straight to EXPIRE
    decr = 1'b1;
    do_load(0);
    check_outs("t3.c0", 0, 1'b1, 1'b1);
    tick(); check_outs("t3.c1", 0, 1'b0, 1'b0);

    // Load 4, clear at count 2 together with a competing load
    do_load(4);
    tick(); tick();
    check_outs("t4.at2", 2, 1'b1, 1'b0);
    clear = 1'b1; load_valid = 1'b1; load_value = 8'd7;
    tick();
    clear = 1'b0; load_valid = 1'b0; load_value = '0;
    check_outs("t4.cleared", 0, 1'b0, 1'b0);
    tick(); check_outs("t4.no_buffer", 0, 1'b0, 1'b0);

    // Clear in IDLE beats a handshake in the same cycle
    clear = 1'b1; load_valid = 1'b1; load_value = 8'd6;
    tick();
    clear = 1'b0; load_valid = 1'b0; load_value = '0;
    check_outs("t5.idle_clear", 0, 1'b0, 1'b0);

    // Maximum load value holds with decr low, then steps by one
    decr = 1'b0;
    do_load(255);
    check_outs("t6.max", 255, 1'b1, 1'b0);
    tick(); check_outs("t6.hold", 255, 1'b1, 1'b0);
    decr = 1'b1;
    tick(); check_outs("t6.dec", 254, 1'b1, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;
    check_outs("t6.clr", 0, 1'b0, 1'b0);

    // Load 200, async reset at count 100
    do_load(200);
    for (int i = 0; i < 100; i++) tick();
    check_outs("t7.at100", 100, 1'b1, 1'b0);
    #2 rstn = 1'b0;
    #1 check_outs("t7.async_rst", 0, 1'b0, 1'b0);
    tick();
    check_outs("t7.in_rst", 0, 1'b0, 1'b0);
    rstn = 1'b1;
    tick();
    do_load(2);
    check_outs("t7.r0", 2, 1'b1, 1'b0);
    tick(); check_outs("t7.r1", 1, 1'b1, 1'b0);
    tick(); check_outs("t7.r2", 0, 1'b1, 1'b1);
    tick(); check_outs("t7.r3", 0, 1'b0, 1'b0);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    // Periodic mode: load 2 gives done every 3 cycles until clear
    do_load(2);
    for (int i = 0; i < 9; i++) begin
      check_val($sformatf("t8.count%0d", i), 32'(count_reg), 32'(2 - (i % 3)));
      check_val($sformatf("t8.done%0d", i), 32'(done), 32'((i % 3) == 2));
      tick();
    end
    clear = 1'b1; tick(); clear = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen++;
      tick();
    end
    check_val("t8.stopped", 32'(done_seen), 32'd0);
    check_outs("t8.idle", 0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
